// File: rtl/ps2_pkg.sv
// Shared constants, event layout and key-lookup helpers for the PS/2 Set-2 scancode decoder.
package ps2_pkg;

  localparam logic [7:0] CODE_E0          = 8'hE0;
  localparam logic [7:0] CODE_F0          = 8'hF0;
  localparam logic [7:0] CODE_E1          = 8'hE1;
  localparam logic [7:0] CODE_FAKE_SHIFT  = 8'h12;
  localparam logic [7:0] CODE_FAKE_NUMLK  = 8'h59;

  localparam logic [7:0] CODE_BAT_OK      = 8'hAA;
  localparam logic [7:0] CODE_ACK         = 8'hFA;
  localparam logic [7:0] CODE_RESEND      = 8'hFE;
  localparam logic [7:0] CODE_ECHO        = 8'hEE;
  localparam logic [7:0] CODE_ERR0        = 8'h00;
  localparam logic [7:0] CODE_ERRF        = 8'hFF;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_P     = 8'h4D;

  localparam int HELD_UP    = 0;
  localparam int HELD_DOWN  = 1;
  localparam int HELD_LEFT  = 2;
  localparam int HELD_RIGHT = 3;
  localparam int HELD_SPACE = 4;
  localparam int HELD_ENTER = 5;
  localparam int HELD_ESC   = 6;
  localparam int HELD_P     = 7;

  localparam int EVT_W       = 10;
  localparam int EVT_REL_BIT = 9;
  localparam int EVT_EXT_BIT = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRE_E0   = 3'd1;
  localparam logic [2:0] ST_PRE_F0   = 3'd2;
  localparam logic [2:0] ST_PRE_E0F0 = 3'd3;
  localparam logic [2:0] ST_SKIP     = 3'd4;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  // Keyboard status/ack bytes that never represent a key.
  function automatic logic is_ignored(input logic [7:0] b);
    logic r;
    case (b)
      CODE_BAT_OK, CODE_ACK, CODE_RESEND, CODE_ECHO, CODE_ERR0, CODE_ERRF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    case ({ext, code})
      {1'b1, KEY_UP}:    m[HELD_UP]    = 1'b1;
      {1'b1, KEY_DOWN}:  m[HELD_DOWN]  = 1'b1;
      {1'b1, KEY_LEFT}:  m[HELD_LEFT]  = 1'b1;
      {1'b1, KEY_RIGHT}: m[HELD_RIGHT] = 1'b1;
      {1'b0, KEY_SPACE}: m[HELD_SPACE] = 1'b1;
      {1'b0, KEY_ENTER}: m[HELD_ENTER] = 1'b1;
      {1'b0, KEY_ESC}:   m[HELD_ESC]   = 1'b1;
      {1'b0, KEY_P}:     m[HELD_P]     = 1'b1;
      default:           m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module evt_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             rd_ok_s;
  logic             wr_ok_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_ok_s = rd && !empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign wr_ok_s = wr && (!full || rd_ok_s);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 byte-stream decoder: prefix FSM, prefix timeout, held-key bitmap and event FIFO.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             evt_rd,
  output logic [EVT_W-1:0] evt_data,
  output logic             evt_empty,
  output logic             evt_overflow,
  output logic [7:0]       held
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    state_r, state_nxt_s;
  logic [2:0]    skip_cnt_r, skip_nxt_s;
  logic [TW-1:0] tmo_cnt_r;
  logic [7:0]    held_r;
  logic          overflow_r;
  logic [2:0]    idle_state_s;
  logic [2:0]    idle_skip_s;
  logic          idle_push_s;
  logic          push_s;
  logic          fifo_full_s;
  logic [7:0]    mask_s;
  evt_t          evt_s;

  // Decode of a byte as seen from IDLE; PRE_E0F0 reuses it for prefix bytes.
  always_comb begin
    idle_state_s = ST_IDLE;
    idle_skip_s  = 3'd0;
    idle_push_s  = 1'b0;
    if (byte_data == CODE_E0) begin
      idle_state_s = ST_PRE_E0;
    end else if (byte_data == CODE_F0) begin
      idle_state_s = ST_PRE_F0;
    end else if (byte_data == CODE_E1) begin
      idle_state_s = ST_SKIP;
      idle_skip_s  = 3'd7;
    end else if (is_ignored(byte_data)) begin
      idle_push_s = 1'b0;
    end else begin
      idle_push_s = 1'b1;
    end
  end

  // Next-state, skip count and event generation.
  always_comb begin
    state_nxt_s = state_r;
    skip_nxt_s  = skip_cnt_r;
    push_s      = 1'b0;
    evt_s       = '{rel: 1'b0, ext: 1'b0, code: byte_data};
    if (byte_valid) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = idle_state_s;
          skip_nxt_s  = idle_skip_s;
          push_s      = idle_push_s;
        end
        ST_PRE_E0: begin
          if (byte_data == CODE_F0) begin
            state_nxt_s = ST_PRE_E0F0;
          end else if (byte_data == CODE_E0) begin
            state_nxt_s = ST_PRE_E0;
          end else if (byte_data == CODE_FAKE_SHIFT || byte_data == CODE_FAKE_NUMLK) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_IDLE;
            push_s      = 1'b1;
            evt_s.ext   = 1'b1;
          end
        end
        ST_PRE_F0: begin
          if (byte_data == CODE_F0) begin
            state_nxt_s = ST_PRE_F0;
          end else if (byte_data == CODE_E0) begin
            state_nxt_s = ST_PRE_E0;
          end else begin
            state_nxt_s = ST_IDLE;
            push_s      = 1'b1;
            evt_s.rel   = 1'b1;
          end
        end
        ST_PRE_E0F0: begin
          if (byte_data == CODE_FAKE_SHIFT || byte_data == CODE_FAKE_NUMLK) begin
            state_nxt_s = ST_IDLE;
          end else if (byte_data == CODE_E0 || byte_data == CODE_F0) begin
            state_nxt_s = idle_state_s;
            skip_nxt_s  = idle_skip_s;
          end else begin
            state_nxt_s = ST_IDLE;
            push_s      = 1'b1;
            evt_s.rel   = 1'b1;
            evt_s.ext   = 1'b1;
          end
        end
        ST_SKIP: begin
          if (skip_cnt_r <= 3'd1) begin
            state_nxt_s = ST_IDLE;
            skip_nxt_s  = 3'd0;
          end else begin
            skip_nxt_s = skip_cnt_r - 3'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          skip_nxt_s  = 3'd0;
        end
      endcase
    end else if (state_r != ST_IDLE && tmo_cnt_r == TMO_LAST) begin
      state_nxt_s = ST_IDLE;
      skip_nxt_s  = 3'd0;
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign mask_s = key_mask(evt_s.ext, evt_s.code);

  // FSM, timeout, held bitmap and sticky overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      skip_cnt_r <= 3'd0;
      tmo_cnt_r  <= {TW{1'b0}};
      held_r     <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      skip_cnt_r <= skip_nxt_s;
      if (byte_valid || state_nxt_s == ST_IDLE) tmo_cnt_r <= {TW{1'b0}};
      else tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      // held follows every emitted event, including ones the FIFO drops.
      if (push_s) held_r <= evt_s.rel ? (held_r & ~mask_s) : (held_r | mask_s);
      if (push_s && fifo_full_s && !evt_rd) overflow_r <= 1'b1;
    end
  end

  assign held         = held_r;
  assign evt_overflow = overflow_r;

  evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (push_s),
    .wr_data (evt_s),
    .rd      (evt_rd),
    .rd_data (evt_data),
    .full    (fifo_full_s),
    .empty   (evt_empty)
  );

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: prefixes, pause skip, held bitmap, FIFO overflow, timeout, reset.
module tb_ps2_scan_decoder;

  localparam int TMO = 50;

  logic       clk;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       evt_rd;
  logic [9:0] evt_data;
  logic       evt_empty;
  logic       evt_overflow;
  logic [7:0] held;

  int checks;
  int errors;

  ps2_scan_decoder #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .evt_rd       (evt_rd),
    .evt_data     (evt_data),
    .evt_empty    (evt_empty),
    .evt_overflow (evt_overflow),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pop();
    @(posedge clk); #1;
    evt_rd = 1'b1;
    @(posedge clk); #1;
    evt_rd = 1'b0;
  endtask

  task automatic send_pop(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = b;
    evt_rd     = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    evt_rd     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    evt_rd     = 1'b0;
    do_reset();

    check("rst_empty", 32'(evt_empty), 32'h1);
    check("rst_data", 32'(evt_data), 32'h000);
    check("rst_ovf", 32'(evt_overflow), 32'h0);
    check("rst_held", 32'(held), 32'h00);

    send(8'h1C);
    check("make_1c", 32'(evt_data), 32'h01C);
    check("make_1c_ne", 32'(evt_empty), 32'h0);
    pop();
    check("pop_empty", 32'(evt_empty), 32'h1);
    send(8'hF0); send(8'h1C);
    check("brk_1c", 32'(evt_data), 32'h21C);
    check("brk_held", 32'(held), 32'h00);
    pop();

    send(8'hE0); send(8'h75);
    check("up_make", 32'(evt_data), 32'h175);
    check("up_held", 32'(held), 32'h01);
    pop();
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_brk", 32'(evt_data), 32'h375);
    check("up_held0", 32'(held), 32'h00);
    pop();

    send(8'hAA); send(8'hFA); send(8'hE0); send(8'h12);
    check("ignored", 32'(evt_empty), 32'h1);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_none", 32'(evt_empty), 32'h1);
    check("pause_held", 32'(held), 32'h00);
    send(8'h29);
    check("space", 32'(evt_data), 32'h029);
    check("space_held", 32'(held), 32'h10);
    pop();
    check("space_pop", 32'(evt_empty), 32'h1);
    send(8'hF0); send(8'h29);
    check("space_brk_held", 32'(held), 32'h00);
    pop();

    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    check("full_noovf", 32'(evt_overflow), 32'h0);
    send(8'h2E);
    check("ovf_set", 32'(evt_overflow), 32'h1);
    check("ovf_head", 32'(evt_data), 32'h016);
    send_pop(8'h36);
    check("rw_head", 32'(evt_data), 32'h01E);
    pop();
    check("q1", 32'(evt_data), 32'h026);
    pop();
    check("q2", 32'(evt_data), 32'h025);
    pop();
    check("q3", 32'(evt_data), 32'h036);
    check("q3_ne", 32'(evt_empty), 32'h0);
    pop();
    check("q_empty", 32'(evt_empty), 32'h1);
    check("ovf_sticky", 32'(evt_overflow), 32'h1);

    send(8'hE0);
    repeat (TMO - 2) @(posedge clk);
    send(8'h75);
    check("tmo_edge", 32'(evt_data), 32'h175);
    pop();
    send(8'hF0); send(8'hF0); send(8'hE0); send(8'hF0); send(8'h75);
    check("held_clr", 32'(held), 32'h00);
    pop();

    send(8'hE0);
    repeat (TMO - 1) @(posedge clk);
    send(8'h1C);
    check("tmo_1c", 32'(evt_data), 32'h01C);
    pop();

    send(8'hF0);
    do_reset();
    check("rst2_ovf", 32'(evt_overflow), 32'h0);
    check("rst2_empty", 32'(evt_empty), 32'h1);
    send(8'h1C);
    check("rst2_1c", 32'(evt_data), 32'h01C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
